syst_psum_drain: RTL and testbench
==================================

Name: syst_psum_drain

Overview:
Output collector at the bottom edge of the systolic array. It receives one partial-sum word and valid bit per column from the last PE row. Column c's result arrives c cycles after column 0's. The block realigns the columns into one row vector and buffers rows in a FIFO. It presents rows downstream with a valid/ready handshake, since the array itself has no backpressure.

Parameters:
COLS, 4, number of array columns (>=2)
SO_WIDTH, 17, partial-sum width per column
DEPTH, 4, FIFO depth in rows (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
clear_i  in  1  synchronous clear: empties FIFO and deskew lines, clears sticky flags
col_valid_i  in  COLS  per-column valid from last PE row
col_psumm_i  in  COLS*SO_WIDTH  per-column psum; column c at bits [c*SO_WIDTH +: SO_WIDTH]
row_psumm_o  out  COLS*SO_WIDTH  aligned row at FIFO head, same packing
row_valid_o  out  1  FIFO not empty
row_ready_i  in  1  downstream accepts row
count_o  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow_o  out  1  sticky: an aligned row was dropped because the FIFO was full
misalign_o  out  1  sticky: aligned valids were partially set

Behaviour:
- Reset: rst_i is asynchronous, active-high; clock is clk_i. On reset, all deskew registers, FIFO pointers and sticky flags go to 0.
  - row_valid_o=0, count_o=0, overflow_o=0, misalign_o=0, row_psumm_o=0 (FIFO storage reset to 0).
- Deskew:
  - Column c passes through a delay line of COLS-1-c register stages, carrying both valid and data.
  - Column COLS-1 has zero stages.
  - Data registers load only when the incoming valid is 1; valid registers load every cycle.
- Aligned vector: av[c] is the delay-line output valid of column c; ad[c] is its data.
- Push condition: push = AND(av), evaluated each cycle.
- Misalignment: if OR(av)=1 and AND(av)=0, misalign_o is set (sticky) and nothing is pushed.
- FIFO:
  - Circular buffer with DEPTH entries, a write pointer and a read pointer. Pointers wrap modulo DEPTH.
  - count_o is tracked explicitly.
  - pop = row_valid_o & row_ready_i.
  - push when not full: write ad[] at wptr; count +1.
  - push when full and pop in the same cycle: the push is accepted; count is unchanged.
  - push when full without pop: the row is dropped; overflow_o is set; FIFO is unchanged.
  - push and pop in the same cycle when not full: both happen; count is unchanged.
  - Pop when empty is impossible, because row_valid_o=0.
- Output path:
  - row_psumm_o reads combinationally from mem[rptr].
  - row_valid_o = (count != 0).
  - row_psumm_o holds stable while row_valid_o=1 and row_ready_i=0.
- Latency: a row whose column COLS-1 valid is sampled high at edge N appears on row_valid_o after edge N. That is, row_valid_o is high in the cycle following edge N, given an empty FIFO.
- Throughput: one row per cycle sustained when row_ready_i=1.
- clear_i:
  - Takes effect at the next edge. Pointers, count, delay-line valids and both sticky flags go to 0.
  - Has priority over push and pop in the same cycle.
  - FIFO data storage is not cleared.
- Reset mid-operation: all in-flight rows are lost. Outputs return to reset values asynchronously.
- Arithmetic: no arithmetic on data; psums pass bit-exact.

Test Plan:
- Single row, COLS=4: drive column c valid at cycle 10+c with psum 100+c, row_ready_i=1 -> row_valid_o=1 for exactly one cycle at cycle 14. row_psumm_o = {103,102,101,100}. count_o returns to 0.
- Backpressure/full: row_ready_i=0, push 5 skewed rows with distinct values -> after row 4, count_o=4. Row 5 is dropped and overflow_o=1. Then row_ready_i=1 pops rows 1-4 in order, unchanged.
- Full with simultaneous pop: FIFO holds 4 rows, row_ready_i=1 on the cycle a 5th row pushes -> overflow_o stays 0, count_o stays 4. Output order is rows 2,3,4,5.
- Misalignment: column 2 valid one cycle late (cycle 13 instead of 12) -> misalign_o=1. No row is pushed for that pattern; count_o unchanged.
- Back-to-back streaming: 8 consecutive skewed rows, row_ready_i=1 -> row_valid_o high 8 consecutive cycles. Values are in order; count_o never exceeds 1.
- clear_i and reset: clear_i pulsed with 3 rows queued and overflow_o=1 -> next cycle count_o=0, row_valid_o=0, overflow_o=0. Asserting rst_i mid-stream forces all outputs to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/syst_psum_drain.sv
// Bottom-edge collector for the systolic array: deskews the staggered per-column
// partial sums into aligned rows and buffers them in a small valid/ready FIFO.
module syst_psum_drain #(
  parameter int COLS     = 4,
  parameter int SO_WIDTH = 17,
  parameter int DEPTH    = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic [COLS-1:0]            col_valid_i,
  input  logic [COLS*SO_WIDTH-1:0]   col_psumm_i,
  output logic [COLS*SO_WIDTH-1:0]   row_psumm_o,
  output logic                       row_valid_o,
  input  logic                       row_ready_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       misalign_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [COLS-1:0][SO_WIDTH-1:0] row_t;

  logic [COLS-1:0]  av;
  row_t             ad;
  row_t             mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, misalign_q;
  logic             push, pop, full, push_ok, partial;

  // Column c is delayed COLS-1-c cycles so that all columns of a row line up
  // with the last column, which arrives undelayed.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int NST = COLS - 1 - c;
    if (NST == 0) begin : g_pass
      assign av[c] = col_valid_i[c];
      assign ad[c] = col_psumm_i[c*SO_WIDTH +: SO_WIDTH];
    end else begin : g_dly
      logic [NST-1:0]               v_q;
      logic [NST-1:0][SO_WIDTH-1:0] d_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: non-blocking assignments make every stage sample the pre-edge value of its neighbour.
        if (rst_i) begin
          v_q <= '0;
          d_q <= '0;
        end else if (clear_i) begin
          v_q <= '0;
        end else begin
          v_q[0] <= col_valid_i[c];
          if (col_valid_i[c]) d_q[0] <= col_psumm_i[c*SO_WIDTH +: SO_WIDTH];
          for (int s = 1; s < NST; s++) begin
            v_q[s] <= v_q[s-1];
            if (v_q[s-1]) d_q[s] <= d_q[s-1];
          end
        end
      end

      assign av[c] = v_q[NST-1];
      assign ad[c] = d_q[NST-1];
    end
  end

  assign row_valid_o = (count_q != '0);

  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    count_d = count_q;
    full    = (count_q == CNT_W'(DEPTH));
    push    = &av;
    partial = (|av) & ~push;
    pop     = row_valid_o & row_ready_i;
    push_ok = push & (~full | pop);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else if (clear_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)     rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
      if (push && full && !pop) overflow_q <= 1'b1;
      if (partial)              misalign_q <= 1'b1;
    end
  end

  // When full with a simultaneous pop, wptr equals rptr: the head is read
  // combinationally this cycle and overwritten at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: storage is reset so the head reads 0 out of reset; clear deliberately leaves it alone.
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!clear_i && push_ok) begin
      mem[wptr_q] <= ad;
    end
  end

  assign row_psumm_o = mem[rptr_q];
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_syst_psum_drain.sv
// Self-checking bench for syst_psum_drain: skewed rows scheduled per cycle,
// checked every cycle against a queue-based row model plus directed scenarios.
module tb_syst_psum_drain;

  localparam int COLS  = 4;
  localparam int W     = 17;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int RW    = COLS * W;
  localparam int HMAX  = 4096;

  typedef logic [RW-1:0] row_t;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             clear_i;
  logic [COLS-1:0]  col_valid_i;
  row_t             col_psumm_i;
  row_t             row_psumm_o;
  logic             row_valid_o;
  logic             row_ready_i;
  logic [CNT_W-1:0] count_o;
  logic             overflow_o;
  logic             misalign_o;

  always #5 clk_i = ~clk_i;

  syst_psum_drain #(.COLS(COLS), .SO_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .col_valid_i (col_valid_i),
    .col_psumm_i (col_psumm_i),
    .row_psumm_o (row_psumm_o),
    .row_valid_o (row_valid_o),
    .row_ready_i (row_ready_i),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .misalign_o  (misalign_o)
  );

  // Per-cycle input schedule; doubles as the input history the model reads.
  bit [COLS-1:0] sv [HMAX];
  bit [RW-1:0]   sd [HMAX];

  int   cyc, valid_from;
  row_t q[$];
  bit   m_ovf, m_mis;
  row_t popped[$];
  bit   s_valid;
  row_t s_data;
  int   s_count, s_cyc;
  int   n_chk, n_fail;

  function automatic row_t rand_row();
    row_t r;
    for (int c = 0; c < COLS; c++) r[c*W +: W] = W'($urandom);
    return r;
  endfunction

  // Column c of a row launched at t0 arrives at t0+c (one cycle later if late).
  task automatic launch(input int t0, input row_t d, input int late_col);
    for (int c = 0; c < COLS; c++) begin
      int t = t0 + c + ((c == late_col) ? 1 : 0);
      sv[t][c] = 1'b1;
      sd[t][c*W +: W] = d[c*W +: W];
    end
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance model.
  task automatic tick();
    bit [COLS-1:0] av;
    row_t          ad;
    bit            mpop, acc;
    col_valid_i = sv[cyc];
    col_psumm_i = sd[cyc];

    n_chk++;
    if (row_valid_o !== (q.size() != 0)) begin
      n_fail++; $display("FAIL row_valid cyc=%0d got=%b exp=%b", cyc, row_valid_o, q.size() != 0);
    end
    n_chk++;
    if (count_o !== CNT_W'(q.size())) begin
      n_fail++; $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, count_o, q.size());
    end
    if (q.size() != 0) begin
      n_chk++;
      if (row_psumm_o !== q[0]) begin
        n_fail++; $display("FAIL row_data cyc=%0d got=%h exp=%h", cyc, row_psumm_o, q[0]);
      end
    end
    n_chk++;
    if (overflow_o !== m_ovf) begin
      n_fail++; $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow_o, m_ovf);
    end
    n_chk++;
    if (misalign_o !== m_mis) begin
      n_fail++; $display("FAIL misalign cyc=%0d got=%b exp=%b", cyc, misalign_o, m_mis);
    end

    s_valid = row_valid_o;
    s_data  = row_psumm_o;
    s_count = int'(count_o);
    s_cyc   = cyc;
    if (row_valid_o === 1'b1 && row_ready_i === 1'b1) popped.push_back(row_psumm_o);

    av = '0;
    ad = '0;
    for (int c = 0; c < COLS; c++) begin
      int idx = cyc - (COLS - 1 - c);
      if (idx >= valid_from) begin
        av[c] = sv[idx][c];
        ad[c*W +: W] = sd[idx][c*W +: W];
      end
    end
    if (clear_i) begin
      q.delete();
      m_ovf = 1'b0;
      m_mis = 1'b0;
      valid_from = cyc + 1;
    end else begin
      if (av != '0 && av != '1) m_mis = 1'b1;
      mpop = (q.size() != 0) && row_ready_i;
      acc  = 1'b0;
      if (av == '1) begin
        if (q.size() < DEPTH || mpop) acc = 1'b1;
        else m_ovf = 1'b1;
      end
      if (mpop) void'(q.pop_front());
      if (acc) q.push_back(ad);
    end

    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if (row_valid_o !== 1'b0 || count_o !== '0) begin
      n_fail++; $display("FAIL reset_valid_count got=%b/%0d exp=0/0", row_valid_o, count_o);
    end
    n_chk++;
    if (overflow_o !== 1'b0 || misalign_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b%b exp=00", overflow_o, misalign_o);
    end
    n_chk++;
    if (row_psumm_o !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0", row_psumm_o);
    end
  endtask

  task automatic test_single_row();
    row_t r;
    int   t0, nv, first;
    row_t got;
    do_clear();
    row_ready_i = 1'b1;
    for (int c = 0; c < COLS; c++) r[c*W +: W] = W'(100 + c);
    t0 = cyc + 1;
    launch(t0, r, -1);
    nv = 0; first = -1; got = '0;
    repeat (COLS + 5) begin
      tick();
      if (s_valid) begin
        nv++;
        if (first < 0) first = s_cyc;
        got = s_data;
      end
    end
    n_chk++;
    if (nv != 1 || first != t0 + COLS) begin
      n_fail++; $display("FAIL single_latency got=%0d cycles at %0d exp=1 at %0d", nv, first, t0 + COLS);
    end
    n_chk++;
    if (got !== r) begin
      n_fail++; $display("FAIL single_data got=%h exp=%h", got, r);
    end
    n_chk++;
    if (count_o !== '0) begin
      n_fail++; $display("FAIL single_count got=%0d exp=0", count_o);
    end
  endtask

  task automatic test_full();
    row_t rows [5];
    int   t0;
    do_clear();
    row_ready_i = 1'b0;
    t0 = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      rows[i] = rand_row();
      launch(t0 + i, rows[i], -1);
    end
    while (cyc <= t0 + 4 + COLS) tick();
    n_chk++;
    if (count_o !== CNT_W'(DEPTH) || overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL full_state got=%0d/%b exp=%0d/1", count_o, overflow_o, DEPTH);
    end
    popped.delete();
    row_ready_i = 1'b1;
    repeat (6) tick();
    row_ready_i = 1'b0;
    n_chk++;
    if (popped.size() != 4) begin
      n_fail++; $display("FAIL full_pop_count got=%0d exp=4", popped.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (popped[i] !== rows[i]) begin
          n_fail++; $display("FAIL full_order idx=%0d got=%h exp=%h", i, popped[i], rows[i]);
        end
      end
    end
  endtask

  task automatic test_full_pop();
    row_t rows [5];
    int   t0;
    do_clear();
    row_ready_i = 1'b0;
    t0 = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      rows[i] = rand_row();
      launch(t0 + i, rows[i], -1);
    end
    while (cyc < t0 + 4 + COLS - 1) tick();
    popped.delete();
    row_ready_i = 1'b1;
    tick();
    row_ready_i = 1'b0;
    n_chk++;
    if (count_o !== CNT_W'(DEPTH) || overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL fullpop_state got=%0d/%b exp=%0d/0", count_o, overflow_o, DEPTH);
    end
    row_ready_i = 1'b1;
    repeat (6) tick();
    row_ready_i = 1'b0;
    n_chk++;
    if (popped.size() != 5) begin
      n_fail++; $display("FAIL fullpop_count got=%0d exp=5", popped.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_chk++;
        if (popped[i] !== rows[i]) begin
          n_fail++; $display("FAIL fullpop_order idx=%0d got=%h exp=%h", i, popped[i], rows[i]);
        end
      end
    end
  endtask

  task automatic test_misalign();
    do_clear();
    row_ready_i = 1'b0;
    launch(cyc + 1, rand_row(), 2);
    repeat (COLS + 4) tick();
    n_chk++;
    if (misalign_o !== 1'b1 || count_o !== '0 || row_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL misalign_state got=%b/%0d/%b exp=1/0/0", misalign_o, count_o, row_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows [8];
    int   t0, run, max_run, max_cnt;
    do_clear();
    row_ready_i = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      rows[i] = rand_row();
      launch(t0 + i, rows[i], -1);
    end
    popped.delete();
    run = 0; max_run = 0; max_cnt = 0;
    repeat (8 + COLS + 4) begin
      tick();
      run = s_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (s_count > max_cnt) max_cnt = s_count;
    end
    n_chk++;
    if (max_run != 8 || max_cnt > 1) begin
      n_fail++; $display("FAIL b2b_stream got run=%0d maxcnt=%0d exp run=8 maxcnt<=1", max_run, max_cnt);
    end
    n_chk++;
    if (popped.size() != 8) begin
      n_fail++; $display("FAIL b2b_count got=%0d exp=8", popped.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_chk++;
        if (popped[i] !== rows[i]) begin
          n_fail++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", i, popped[i], rows[i]);
        end
      end
    end
  endtask

  task automatic test_clear();
    int t0;
    do_clear();
    row_ready_i = 1'b0;
    t0 = cyc + 1;
    for (int i = 0; i < 5; i++) launch(t0 + i, rand_row(), -1);
    while (cyc <= t0 + 4 + COLS) tick();
    row_ready_i = 1'b1;
    tick();
    row_ready_i = 1'b0;
    n_chk++;
    if (count_o !== CNT_W'(3) || overflow_o !== 1'b1) begin
      n_fail++; $display("FAIL clear_pre got=%0d/%b exp=3/1", count_o, overflow_o);
    end
    do_clear();
    n_chk++;
    if (count_o !== '0 || row_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
      n_fail++; $display("FAIL clear_post got=%0d/%b/%b exp=0/0/0", count_o, row_valid_o, overflow_o);
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    int t;
    do_clear();
    t = cyc + 1;
    for (int i = 0; i < 40; i++) begin
      launch(t, rand_row(), -1);
      t += 1 + int'($urandom_range(0, 2));
    end
    while (cyc < t + COLS + 12) begin
      row_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    row_ready_i = 1'b1;
    repeat (DEPTH + 2) tick();
  endtask

  task automatic test_reset_async();
    int t0;
    do_clear();
    row_ready_i = 1'b0;
    t0 = cyc + 1;
    for (int i = 0; i < 3; i++) launch(t0 + i, rand_row(), -1);
    while (cyc < t0 + COLS + 2) tick();
    #3 rst_i = 1'b1;
    #1;
    n_chk++;
    if (row_valid_o !== 1'b0 || count_o !== '0 || row_psumm_o !== '0) begin
      n_fail++; $display("FAIL async_reset_out got=%b/%0d/%h exp=0/0/0", row_valid_o, count_o, row_psumm_o);
    end
    n_chk++;
    if (overflow_o !== 1'b0 || misalign_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_flags got=%b%b exp=00", overflow_o, misalign_o);
    end
    q.delete();
    m_ovf = 1'b0;
    m_mis = 1'b0;
    repeat (2) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    rst_i = 1'b0;
    valid_from = cyc;
    repeat (COLS + 2) tick();
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    cyc = 0; valid_from = 0;
    m_ovf = 1'b0; m_mis = 1'b0;
    rst_i = 1'b1; clear_i = 1'b0; row_ready_i = 1'b0;
    col_valid_i = '0; col_psumm_i = '0;
    #1;
    test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    test_single_row();
    test_full();
    test_full_pop();
    test_misalign();
    test_back_to_back();
    test_clear();
    test_random();
    test_reset_async();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
